// File: rtl/servile_arbiter_n_pkg.sv
// Shared state encoding, arbitration mode names and counter sizing for the
// servile N-master Wishbone arbiter.
package servile_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam string MODE_RR    = "RR";
  localparam string MODE_FIXED = "FIXED";

  // Kept at least 1 bit wide so the register declaration stays legal when TIMEOUT=0.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/servile_arbiter_n_if.sv
// Bundle of the N initiator ports, the shared target port, the grant vector
// and FSM debug taps of the servile arbiter.
interface servile_arbiter_n_if #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  import servile_arb_pkg::*;

  localparam int SW = DW / 8;
  localparam int PW = $clog2(NUM_MASTERS);

  // Handshake: a master raises stb (cyc+stb) and holds it with stable fields until
  // it sees its ack or err; the target acks one cycle per request, and ack/err on
  // a master port are only meaningful while that master is asserting stb.
  logic [NUM_MASTERS*AW-1:0] i_wb_m_adr;
  logic [NUM_MASTERS*DW-1:0] i_wb_m_dat;
  logic [NUM_MASTERS*SW-1:0] i_wb_m_sel;
  logic [NUM_MASTERS-1:0]    i_wb_m_we;
  logic [NUM_MASTERS-1:0]    i_wb_m_stb;
  logic [DW-1:0]             o_wb_m_rdt;
  logic [NUM_MASTERS-1:0]    o_wb_m_ack;
  logic [NUM_MASTERS-1:0]    o_wb_m_err;

  logic [AW-1:0]             o_wb_s_adr;
  logic [DW-1:0]             o_wb_s_dat;
  logic [SW-1:0]             o_wb_s_sel;
  logic                      o_wb_s_we;
  logic                      o_wb_s_stb;
  logic [DW-1:0]             i_wb_s_rdt;
  logic                      i_wb_s_ack;

  logic [NUM_MASTERS-1:0]    o_grant;
  arb_state_t                dbg_state;
  logic [PW-1:0]             dbg_ptr;

  modport slave (
    input  i_wb_m_adr, i_wb_m_dat, i_wb_m_sel, i_wb_m_we, i_wb_m_stb,
    input  i_wb_s_rdt, i_wb_s_ack,
    output o_wb_m_rdt, o_wb_m_ack, o_wb_m_err,
    output o_wb_s_adr, o_wb_s_dat, o_wb_s_sel, o_wb_s_we, o_wb_s_stb,
    output o_grant, dbg_state, dbg_ptr
  );

  modport master (
    output i_wb_m_adr, i_wb_m_dat, i_wb_m_sel, i_wb_m_we, i_wb_m_stb,
    output i_wb_s_rdt, i_wb_s_ack,
    input  o_wb_m_rdt, o_wb_m_ack, o_wb_m_err,
    input  o_wb_s_adr, o_wb_s_dat, o_wb_s_sel, o_wb_s_we, o_wb_s_stb,
    input  o_grant, dbg_state, dbg_ptr
  );

endinterface

// File: rtl/servile_arbiter_n_rr_pick.sv
// Rotating-priority encoder: returns the one-hot first requester found when
// searching upward from ptr, wrapping modulo N.
module servile_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         win
);
  localparam int PW = $clog2(N);

  int idx;

  // Walk offsets from far to near so the nearest requester overwrites the rest.
  always_comb begin
    win = '0;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[PW'(idx)]) begin
        win          = '0;
        win[PW'(idx)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/servile_arbiter_n.sv
// N-master classic Wishbone arbiter: fixed-priority or round-robin ownership,
// held until ack, abort on stb drop, bounded timeout returning a one-cycle err.
module servile_arbiter_n
  import servile_arb_pkg::*;
#(
  parameter int    NUM_MASTERS = 2,
  parameter int    AW          = 32,
  parameter int    DW          = 32,
  parameter string MODE        = MODE_RR,
  parameter int    TIMEOUT     = 255
) (
  input logic                i_clk,
  input logic                i_rst,
  servile_arbiter_n_if.slave bus
);
  localparam int SW    = DW / 8;
  localparam int PW    = $clog2(NUM_MASTERS);
  localparam int CW    = cnt_width(TIMEOUT);
  localparam bit IS_RR = (MODE == MODE_RR);

  arb_state_t             state, state_nxt;
  logic [NUM_MASTERS-1:0] grant, grant_nxt;
  logic [NUM_MASTERS-1:0] err, err_nxt;
  logic [NUM_MASTERS-1:0] win;
  logic [PW-1:0]          ptr, ptr_nxt, pick_ptr, owner, owner_inc;
  logic [CW-1:0]          cnt, cnt_nxt, cnt_inc;
  logic                   owner_stb;
  logic                   timeout_hit;

  // Fixed priority is the rotating encoder with the search always starting at 0.
  assign pick_ptr = IS_RR ? ptr : '0;

  servile_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req (bus.i_wb_m_stb),
    .ptr (pick_ptr),
    .win (win)
  );

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) owner = PW'(i);
    end
  end

  assign owner_inc = (owner == PW'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;
  // grant is zero outside BUSY, so this is also the BUSY qualifier.
  assign owner_stb = |(grant & bus.i_wb_m_stb);

  if (TIMEOUT > 0) begin : g_timeout
    assign cnt_inc     = (cnt == CW'(TIMEOUT)) ? cnt : cnt + 1'b1;
    assign timeout_hit = owner_stb && !bus.i_wb_s_ack && (cnt_inc == CW'(TIMEOUT));
  end else begin : g_no_timeout
    assign cnt_inc     = '0;
    assign timeout_hit = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
      cnt   <= '0;
      err   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  // Exit priority in BUSY: ack, then abort (owner dropped stb), then timeout.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    err_nxt   = '0;
    case (state)
      IDLE: begin
        if (|bus.i_wb_m_stb) begin
          state_nxt = BUSY;
          grant_nxt = win;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        cnt_nxt = cnt_inc;
        if (bus.i_wb_s_ack || !owner_stb || timeout_hit) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          cnt_nxt   = '0;
          if (IS_RR) ptr_nxt = owner_inc;
          if (timeout_hit) err_nxt = grant;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_comb begin
    bus.o_wb_s_adr = '0;
    bus.o_wb_s_dat = '0;
    bus.o_wb_s_sel = '0;
    bus.o_wb_s_we  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        bus.o_wb_s_adr = bus.i_wb_m_adr[i*AW +: AW];
        bus.o_wb_s_dat = bus.i_wb_m_dat[i*DW +: DW];
        bus.o_wb_s_sel = bus.i_wb_m_sel[i*SW +: SW];
        bus.o_wb_s_we  = bus.i_wb_m_we[i];
      end
    end
  end

  assign bus.o_wb_s_stb = owner_stb;
  assign bus.o_wb_m_ack = grant & {NUM_MASTERS{bus.i_wb_s_ack}};
  assign bus.o_wb_m_err = err;
  assign bus.o_wb_m_rdt = bus.i_wb_s_rdt;
  assign bus.o_grant    = grant;
  assign bus.dbg_state  = state;
  assign bus.dbg_ptr    = ptr;

endmodule
